// File: rtl/m_axi_read_engine_v2.sv
// -----------------------------------------------------------------------------
// m_axi_read_engine_v2
// AXI4 master read engine between an HLS/TAPA mmap read port and an m_axi bus.
// Each request (start byte address, length in beats) is split into INCR bursts
// of at most MAX_BURST_LEN beats, none of which crosses a 4 KB boundary. The
// number of bursts in flight is limited to NUM_OUTSTANDING. Read data is
// returned in order through a 2-entry skid slice. RLAST is reported as
// rd_last = {burst_end, request_end}.
//
// Ports
//   ACLK, ARESETN (sync, active low), ACLK_EN (0 = all state holds)
//   m_AR*  : read address channel (ARSIZE/ARBURST constant, single ID)
//   m_R*   : read data channel
//   req_*  : request in (addr, len in beats, valid/ready)
//   rd_*   : data out (data, last[1:0], valid/ready)
//   err_flag, err_count : RRESP error reporting, only with the macro below
//
// Optional feature macro: M_AXI_READ_RRESP_CHECK_EN
//   Defined   -> sticky err_flag and saturating 16-bit err_count on any R beat
//                with RRESP[1]=1 (SLVERR/DECERR); data still forwarded.
//   Undefined -> no error ports, RRESP ignored.
// -----------------------------------------------------------------------------
module m_axi_read_engine_v2 #(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 512,
  parameter int LEN_WIDTH       = 32,
  parameter int MAX_BURST_LEN   = 64,
  parameter int NUM_OUTSTANDING = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  ACLK_EN,
  output logic [ADDR_WIDTH-1:0] m_ARADDR,
  output logic [7:0]            m_ARLEN,
  output logic [2:0]            m_ARSIZE,
  output logic [1:0]            m_ARBURST,
  output logic                  m_ARVALID,
  input  logic                  m_ARREADY,
  input  logic [DATA_WIDTH-1:0] m_RDATA,
  input  logic [1:0]            m_RRESP,
  input  logic                  m_RLAST,
  input  logic                  m_RVALID,
  output logic                  m_RREADY,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready
`ifdef M_AXI_READ_RRESP_CHECK_EN
  ,
  output logic                  err_flag,
  output logic [15:0]           err_count
`endif
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int OST_W = $clog2(NUM_OUTSTANDING) + 1;
  localparam int PTR_W = $clog2(NUM_OUTSTANDING);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);
  localparam logic [OST_W-1:0]      OST_MAX    = OST_W'(NUM_OUTSTANDING);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic                  r_arvalid;
  logic                  r_req_ready;
  logic [OST_W-1:0]      r_ost;
  logic [OST_W-1:0]      r_fcnt;
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic                  r_fifo [NUM_OUTSTANDING];
  logic [1:0]            r_rcnt;
  logic                  r_rready;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_d0;
  logic [DATA_WIDTH-1:0] r_d1;
  logic                  r_l0;
  logic                  r_l1;

  logic [12:0]           w_to4k;
  logic [8:0]            w_cap;
  logic [8:0]            w_blen;
  logic                  w_last_burst;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_rlast_hs;
  logic                  w_rd_hs;
  logic                  w_fifo_pop;
  logic [OST_W-1:0]      w_ost_next;
  logic [OST_W-1:0]      w_fcnt_next;
  logic                  w_can_issue;
  logic [1:0]            w_rcnt_next;

  // Beats left before the next 4 KB boundary; r_addr is always beat aligned.
  assign w_to4k       = (13'd4096 - {1'b0, r_addr[11:0]}) >> SIZE;
  assign w_cap        = (w_to4k < 13'(MAX_BURST_LEN)) ? w_to4k[8:0] : 9'(MAX_BURST_LEN);
  assign w_blen       = (r_rem < LEN_WIDTH'(w_cap)) ? r_rem[8:0] : w_cap;
  assign w_last_burst = (r_rem == LEN_WIDTH'(w_blen));

  assign w_ar_hs     = r_arvalid & m_ARREADY;
  assign w_r_hs      = m_RVALID & r_rready;
  assign w_rlast_hs  = w_r_hs & m_RLAST;
  assign w_rd_hs     = r_rd_valid & rd_ready;
  assign w_fifo_pop  = w_rd_hs & r_l0 & (r_fcnt != '0);
  assign w_ost_next  = r_ost + OST_W'(w_ar_hs) - OST_W'(w_rlast_hs);
  assign w_fcnt_next = r_fcnt + OST_W'(w_ar_hs) - OST_W'(w_fifo_pop);
  // The info FIFO also holds entries for bursts whose RLAST sits in the skid
  // slice but has not left yet, so its occupancy gates AR alongside ost_cnt.
  assign w_can_issue = (w_ost_next < OST_MAX) && (w_fcnt_next < OST_MAX);
  assign w_rcnt_next = r_rcnt + 2'(w_r_hs) - 2'(w_rd_hs);

  assign m_ARADDR  = r_addr;
  assign m_ARLEN   = 8'(w_blen - 9'd1);
  assign m_ARSIZE  = 3'(SIZE);
  assign m_ARBURST = 2'b01;
  assign m_ARVALID = r_arvalid;
  assign req_ready = r_req_ready;
  assign m_RREADY  = r_rready;
  assign rd_data   = r_d0;
  assign rd_valid  = r_rd_valid;
  assign rd_last[1] = r_rd_valid & r_l0;
  assign rd_last[0] = r_rd_valid & r_l0 & r_fifo[r_rptr] & (r_fcnt != '0);

  // Request FSM: accept, then walk the request burst by burst.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rem       <= '0;
      r_arvalid   <= 1'b0;
      r_req_ready <= 1'b0;
    end else if (ACLK_EN) begin
      case (r_state)
        S_IDLE: begin
          if (r_req_ready && req_valid) begin
            r_addr <= req_addr & ALIGN_MASK;
            r_rem  <= req_len;
            if (req_len != '0) begin
              r_state     <= S_ISSUE;
              r_req_ready <= 1'b0;
              r_arvalid   <= w_can_issue;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (w_ar_hs) begin
            r_addr <= r_addr + (ADDR_WIDTH'(w_blen) << SIZE);
            r_rem  <= r_rem - LEN_WIDTH'(w_blen);
            if (w_last_burst) begin
              r_state     <= S_IDLE;
              r_arvalid   <= 1'b0;
              r_req_ready <= 1'b1;
            end else begin
              r_arvalid <= w_can_issue;
            end
          end else begin
            r_arvalid <= r_arvalid | w_can_issue;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outstanding-burst counter and burst-info FIFO pointers.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_ost  <= '0;
      r_fcnt <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (ACLK_EN) begin
      r_ost  <= w_ost_next;
      r_fcnt <= w_fcnt_next;
      if (w_ar_hs)    r_wptr <= r_wptr + 1'b1;
      if (w_fifo_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

  // FIFO storage: one bit per burst, set when the burst ends its request.
  always_ff @(posedge ACLK) begin
    if (ACLK_EN && w_ar_hs) r_fifo[r_wptr] <= w_last_burst;
  end

  // 2-entry R skid slice; r_d0/r_l0 is always the head presented on rd_*.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_rcnt     <= '0;
      r_rready   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_l0       <= 1'b0;
      r_l1       <= 1'b0;
    end else if (ACLK_EN) begin
      r_rcnt     <= w_rcnt_next;
      r_rready   <= (w_rcnt_next != 2'd2);
      r_rd_valid <= (w_rcnt_next != 2'd0);
      if (w_rd_hs) begin
        if (r_rcnt == 2'd2) begin
          r_d0 <= r_d1;
          r_l0 <= r_l1;
        end else if (w_r_hs) begin
          r_d0 <= m_RDATA;
          r_l0 <= m_RLAST;
        end
      end else if (w_r_hs) begin
        if (r_rcnt == 2'd0) begin
          r_d0 <= m_RDATA;
          r_l0 <= m_RLAST;
        end else begin
          r_d1 <= m_RDATA;
          r_l1 <= m_RLAST;
        end
      end
    end
  end

`ifdef M_AXI_READ_RRESP_CHECK_EN
  logic w_unused_resp;
  assign w_unused_resp = m_RRESP[0];

  // RRESP[1] covers both SLVERR and DECERR.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      err_flag  <= 1'b0;
      err_count <= '0;
    end else if (ACLK_EN && w_r_hs && m_RRESP[1]) begin
      err_flag <= 1'b1;
      if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
`else
  logic w_unused_resp;
  assign w_unused_resp = ^m_RRESP;
`endif

endmodule
